// File: rtl/lsu_ctrl_pkg.sv
// ============================================================================
// Module  : lsu_ctrl_pkg
// Purpose : Shared access-size codes, address-map defaults and decode helper
//           for the load/store sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_ctrl_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  localparam logic [31:0] LSU_RAM_BASE_DEF  = 32'h0001_0000;
  localparam logic [31:0] LSU_MMIO_BASE_DEF = 32'h0002_0000;

  // Size code 3 is not a legal access and is reported like a misalignment.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SIZE_B: lsu_misaligned = 1'b0;
      LSU_SIZE_H: lsu_misaligned = off[0];
      LSU_SIZE_W: lsu_misaligned = (off != 2'b00);
      default:    lsu_misaligned = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module  : lsu_align
// Purpose : Store byte-enable/data replication and load shift/extend.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] w_shift;

  always_comb begin
    w_shift = rdata_i >> {offset_i, 3'b000};
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = w_shift;
    case (size_i)
      LSU_SIZE_B: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      LSU_SIZE_H: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      LSU_SIZE_W: begin
        be_o = 4'b1111;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module  : lsu_ctrl
// Purpose : Load/store sequencer driving data RAM or fifo_if register window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned RAM_AW    = 10,
  parameter logic [31:0] RAM_BASE  = LSU_RAM_BASE_DEF,
  parameter logic [31:0] MMIO_BASE = LSU_MMIO_BASE_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              fifo_sel_o,
  output logic              fifo_rd_o,
  output logic              fifo_wr_o,
  output logic [1:0]        fifo_addr_o,
  output logic [7:0]        fifo_wrdata_o,
  input  logic [7:0]        fifo_rddata_i
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  logic [1:0]  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic        r_mmio;
  logic        r_err;
  logic [31:0] r_data;

  logic        w_ram_hit;
  logic        w_mmio_hit;
  logic        w_err;
  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_ram_hit  = (addr_i[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
  assign w_mmio_hit = (addr_i[31:2] == MMIO_BASE[31:2]);
  assign w_err      = lsu_misaligned(size_i, addr_i[1:0])
                    | (!w_ram_hit && !w_mmio_hit)
                    | (w_mmio_hit && (size_i != LSU_SIZE_B));

  // One aligner: live request while accepting, latched request afterwards.
  assign w_size = (r_state == c_idle) ? size_i      : r_size;
  assign w_off  = (r_state == c_idle) ? addr_i[1:0] : r_off;

  lsu_align u_align (
    .size_i     (w_size),
    .unsigned_i (r_uns),
    .offset_i   (w_off),
    .wdata_i    (wdata_i),
    .rdata_i    (r_data),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .rdata_o    (w_ext)
  );

  assign stall_o = ((r_state == c_idle) && req_i) || (r_state == c_issue) || (r_state == c_wait);
  assign done_o  = (r_state == c_done);
  assign err_o   = (r_state == c_done) && r_err;
  assign rdata_o = ((r_state == c_done) && !r_we && !r_err) ? w_ext : 32'd0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= c_idle;
      r_we          <= 1'b0;
      r_size        <= LSU_SIZE_B;
      r_uns         <= 1'b0;
      r_off         <= 2'd0;
      r_mmio        <= 1'b0;
      r_err         <= 1'b0;
      r_data        <= 32'd0;
      ram_en_o      <= 1'b0;
      ram_we_o      <= 4'd0;
      ram_addr_o    <= '0;
      ram_wdata_o   <= 32'd0;
      fifo_sel_o    <= 1'b0;
      fifo_rd_o     <= 1'b0;
      fifo_wr_o     <= 1'b0;
      fifo_addr_o   <= 2'd0;
      fifo_wrdata_o <= 8'd0;
    end else begin
      ram_en_o   <= 1'b0;
      ram_we_o   <= 4'd0;
      fifo_sel_o <= 1'b0;
      fifo_rd_o  <= 1'b0;
      fifo_wr_o  <= 1'b0;
      case (r_state)
        c_idle: begin
          if (req_i) begin
            r_we   <= we_i;
            r_size <= size_i;
            r_uns  <= unsigned_i;
            r_off  <= addr_i[1:0];
            r_mmio <= w_mmio_hit;
            r_err  <= w_err;
            if (w_err) begin
              r_state <= c_done;
            end else begin
              r_state <= c_issue;
              if (w_mmio_hit) begin
                fifo_sel_o    <= 1'b1;
                fifo_rd_o     <= !we_i;
                fifo_wr_o     <= we_i;
                fifo_addr_o   <= addr_i[1:0];
                fifo_wrdata_o <= wdata_i[7:0];
              end else begin
                ram_en_o    <= 1'b1;
                ram_we_o    <= we_i ? w_be : 4'd0;
                ram_addr_o  <= addr_i[RAM_AW+1:2];
                ram_wdata_o <= w_wdata;
              end
            end
          end
        end
        c_issue: r_state <= r_we ? c_done : c_wait;
        c_wait: begin
          // Replicating the FIFO byte lets the common shift pick it at any offset.
          r_data  <= r_mmio ? {4{fifo_rddata_i}} : ram_rdata_i;
          r_state <= c_done;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module  : tb_lsu_ctrl
// Purpose : Directed scoreboard bench for lsu_ctrl with RAM and fifo_if models.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        stall_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = 32'd0;
  logic        fifo_sel_o, fifo_rd_o, fifo_wr_o;
  logic [1:0]  fifo_addr_o;
  logic [7:0]  fifo_wrdata_o;
  logic [7:0]  fifo_rddata_i = 8'd0;

  lsu_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .ram_en_o(ram_en_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i), .fifo_sel_o(fifo_sel_o), .fifo_rd_o(fifo_rd_o),
    .fifo_wr_o(fifo_wr_o), .fifo_addr_o(fifo_addr_o), .fifo_wrdata_o(fifo_wrdata_o),
    .fifo_rddata_i(fifo_rddata_i)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mem [0:1023];
  logic [7:0]  fregs [0:3];

  always @(posedge clk_i) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o];
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
    if (fifo_sel_o && fifo_wr_o) fregs[fifo_addr_o] <= fifo_wrdata_o;
    if (fifo_sel_o && fifo_rd_o) fifo_rddata_i <= fregs[fifo_addr_o];
  end

  int          ram_cnt = 0, fifo_cnt = 0, done_cnt = 0;
  logic [3:0]  l_we;
  logic [9:0]  l_addr;
  logic [31:0] l_wd;
  logic        l_fwr, l_frd;
  logic [1:0]  l_fa;
  logic [7:0]  l_fwd;

  always @(negedge clk_i) begin
    if (ram_en_o) begin
      ram_cnt++; l_we = ram_we_o; l_addr = ram_addr_o; l_wd = ram_wdata_o;
    end
    if (fifo_sel_o) begin
      fifo_cnt++; l_fwr = fifo_wr_o; l_frd = fifo_rd_o; l_fa = fifo_addr_o; l_fwd = fifo_wrdata_o;
    end
    if (done_o) done_cnt++;
  end

  typedef struct { logic [31:0] rd; logic err; } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input int exp_ram,
                       input int exp_fifo, input logic hold);
    int cyc, ram0, fifo0;
    bit seen;
    exp_t e;
    ram0 = ram_cnt; fifo0 = fifo_cnt;
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    sb_q.push_back('{rd: exp_rd, err: exp_err});
    #1;
    chk({tag, " stall_c0"}, stall_o, 1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 8) begin
      @(posedge clk_i); #1;
      cyc++;
      if (!hold) req_i = 1'b0;
      if (done_o) begin
        seen = 1;
        if (sb_q.size() == 0) begin
          chk({tag, " sb_empty"}, 0, 1);
        end else begin
          e = sb_q.pop_front();
          chk({tag, " rdata"}, rdata_o, e.rd);
          chk({tag, " err"}, err_o, e.err);
        end
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " stall_done"}, stall_o, 0);
      end else begin
        chk({tag, " stall_busy"}, stall_o, 1);
      end
    end
    if (!seen) chk({tag, " timeout"}, 0, 1);
    chk({tag, " ram_pulses"}, ram_cnt - ram0, exp_ram);
    chk({tag, " fifo_pulses"}, fifo_cnt - fifo0, exp_fifo);
    @(posedge clk_i); #1;
  endtask

  task automatic chk_ram(input string tag, input logic [3:0] we, input logic [9:0] a, input logic [31:0] wd);
    chk({tag, " ram_we"}, l_we, we);
    chk({tag, " ram_addr"}, l_addr, a);
    chk({tag, " ram_wdata"}, l_wd, wd);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " stall"}, stall_o, 0);
    chk({tag, " done"}, done_o, 0);
    chk({tag, " err"}, err_o, 0);
    chk({tag, " rdata"}, rdata_o, 0);
    chk({tag, " ram_en"}, ram_en_o, 0);
    chk({tag, " ram_we"}, ram_we_o, 0);
    chk({tag, " ram_addr"}, ram_addr_o, 0);
    chk({tag, " ram_wdata"}, ram_wdata_o, 0);
    chk({tag, " fifo_strb"}, {fifo_sel_o, fifo_rd_o, fifo_wr_o}, 0);
    chk({tag, " fifo_addr"}, fifo_addr_o, 0);
    chk({tag, " fifo_wrdata"}, fifo_wrdata_o, 0);
  endtask

  int d0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 4; i++) fregs[i] = 8'd0;

    repeat (2) @(posedge clk_i);
    #1;
    chk_idle_outputs("reset");
    #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // RAM stores and loads
    do_op("sw", 1, 2'd2, 0, 32'h0001_0004, 32'hDEAD_BEEF, 32'd0, 0, 2, 1, 0, 0);
    chk_ram("sw", 4'b1111, 10'd1, 32'hDEAD_BEEF);
    do_op("sb", 1, 2'd0, 0, 32'h0001_0007, 32'h1234_56A5, 32'd0, 0, 2, 1, 0, 0);
    chk_ram("sb", 4'b1000, 10'd1, 32'hA5A5_A5A5);
    do_op("lb", 0, 2'd0, 0, 32'h0001_0007, 32'd0, 32'hFFFF_FFA5, 0, 3, 1, 0, 0);
    chk({"lb ram_we"}, l_we, 4'b0000);
    do_op("lbu", 0, 2'd0, 1, 32'h0001_0007, 32'd0, 32'h0000_00A5, 0, 3, 1, 0, 0);
    do_op("lb0", 0, 2'd0, 0, 32'h0001_0004, 32'd0, 32'hFFFF_FFEF, 0, 3, 1, 0, 0);
    do_op("lh", 0, 2'd1, 0, 32'h0001_0006, 32'd0, 32'hFFFF_A5AD, 0, 3, 1, 0, 0);
    do_op("lhu", 0, 2'd1, 1, 32'h0001_0006, 32'd0, 32'h0000_A5AD, 0, 3, 1, 0, 0);
    do_op("lw", 0, 2'd2, 0, 32'h0001_0004, 32'd0, 32'hA5AD_BEEF, 0, 3, 1, 0, 0);
    do_op("sh", 1, 2'd1, 0, 32'h0001_0002, 32'hFFFF_1234, 32'd0, 0, 2, 1, 0, 0);
    chk_ram("sh", 4'b1100, 10'd0, 32'h1234_1234);
    do_op("lh_hi", 0, 2'd1, 0, 32'h0001_0002, 32'd0, 32'h0000_1234, 0, 3, 1, 0, 0);
    do_op("lb_hi", 0, 2'd0, 0, 32'h0001_0003, 32'd0, 32'h0000_0012, 0, 3, 1, 0, 0);

    // misaligned
    do_op("lh_mis", 0, 2'd1, 0, 32'h0001_0003, 32'd0, 32'd0, 1, 1, 0, 0, 0);
    do_op("sw_mis", 1, 2'd2, 0, 32'h0001_0002, 32'h1111_1111, 32'd0, 1, 1, 0, 0, 0);

    // fifo_if window
    do_op("fsb", 1, 2'd0, 0, 32'h0002_0001, 32'h0000_0041, 32'd0, 0, 2, 0, 1, 0);
    chk("fsb wr", l_fwr, 1);
    chk("fsb addr", l_fa, 2'd1);
    chk("fsb wrdata", l_fwd, 8'h41);
    do_op("flb", 0, 2'd0, 0, 32'h0002_0001, 32'd0, 32'h0000_0041, 0, 3, 0, 1, 0);
    chk("flb rd", {l_frd, l_fwr}, 2'b10);
    do_op("fsb3", 1, 2'd0, 0, 32'h0002_0003, 32'hFFFF_FF80, 32'd0, 0, 2, 0, 1, 0);
    do_op("flb3", 0, 2'd0, 0, 32'h0002_0003, 32'd0, 32'hFFFF_FF80, 0, 3, 0, 1, 0);
    do_op("flbu3", 0, 2'd0, 1, 32'h0002_0003, 32'd0, 32'h0000_0080, 0, 3, 0, 1, 0);
    do_op("flw_err", 0, 2'd2, 0, 32'h0002_0000, 32'd0, 32'd0, 1, 1, 0, 0, 0);
    do_op("fsh_err", 1, 2'd1, 0, 32'h0002_0000, 32'd0, 32'd0, 1, 1, 0, 0, 0);

    // unmapped, with req held high through DONE
    do_op("unmap_hold", 0, 2'd2, 0, 32'h0003_0000, 32'd0, 32'd0, 1, 1, 0, 0, 1);
    do_op("unmap_next", 0, 2'd2, 0, 32'h0003_0000, 32'd0, 32'd0, 1, 1, 0, 0, 0);
    do_op("sw_hold", 1, 2'd2, 0, 32'h0001_0008, 32'hCAFE_F00D, 32'd0, 0, 2, 1, 0, 1);
    do_op("sw_next", 1, 2'd2, 0, 32'h0001_0008, 32'hCAFE_F00D, 32'd0, 0, 2, 1, 0, 0);
    chk_ram("sw_next", 4'b1111, 10'd2, 32'hCAFE_F00D);

    // reset during ISSUE: strobe drops immediately
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; addr_i = 32'h0001_000C; wdata_i = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    chk("abort_issue ram_en_pre", ram_en_o, 1);
    rstn_i = 1'b0;
    #1;
    chk_idle_outputs("abort_issue");
    #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // reset during WAIT: no retire, then a fresh store
    d0 = done_cnt;
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h0001_0004;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(posedge clk_i); #1;
    rstn_i = 1'b0;
    #1;
    chk_idle_outputs("abort_wait");
    @(posedge clk_i); #2;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    chk("abort_wait no_retire", done_cnt - d0, 0);
    do_op("sw_after_rst", 1, 2'd2, 0, 32'h0001_0010, 32'h0BAD_F00D, 32'd0, 0, 2, 1, 0, 0);
    chk_ram("sw_after_rst", 4'b1111, 10'd4, 32'h0BAD_F00D);
    do_op("lw_after_rst", 0, 2'd2, 0, 32'h0001_0010, 32'd0, 32'h0BAD_F00D, 0, 3, 1, 0, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
